// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the run-control / state-dump sequencer:
//   - host command encodings (cmd_e)
//   - FSM state encodings (state_e), visible on o_debug_state
//   - bytes_per_word(): UART bytes needed for one core word
//   - total_words(): number of words in one dump (counter, PC, regs, mem)
// Optional feature macro used by the dump unit: DEBUG_DUMP_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package debug_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_DUMP = 2'b11
    } cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_RUN   = 4'd1,
        ST_STEP  = 4'd2,
        ST_LOAD  = 4'd3,
        ST_LATCH = 4'd4,
        ST_SEND  = 4'd5,
        ST_WAIT  = 4'd6,
        ST_DONE  = 4'd7
    } state_e;

    function automatic int bytes_per_word(input int nbits, input int data_bits);
        return nbits / data_bits;
    endfunction

    // Word 0 = cycle counter, word 1 = PC, then registers, then memory.
    function automatic int total_words(input int n_regs, input int n_mem_words);
        return 2 + n_regs + n_mem_words;
    endfunction

    localparam int DEFAULT_TOTAL_WORDS = 50;

endpackage

// File: rtl/debug_word_serializer.sv
// -----------------------------------------------------------------------------
// debug_word_serializer
// Holds one NBITS word and presents it DATA_BITS at a time.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture word, restart at byte 0
//   next       : advance to the following byte
//   word       : word to serialise
//   tx_byte    : current byte (stable until next/load)
//   last       : current byte is the final byte of the word
// MSB_FIRST = 0 emits the least significant byte first, 1 the most significant.
// -----------------------------------------------------------------------------
module debug_word_serializer
    import debug_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int DATA_BITS = 8,
    parameter int MSB_FIRST = 0
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 next,
    input  logic [NBITS-1:0]     word,
    output logic [DATA_BITS-1:0] tx_byte,
    output logic                 last
);

    localparam int B        = bytes_per_word(NBITS, DATA_BITS);
    localparam int IDX_BITS = (B > 1) ? $clog2(B) : 1;

    logic [NBITS-1:0]    shreg_r;
    logic [IDX_BITS-1:0] idx_r;

    // Shift register and byte index: load restarts, next consumes one byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r <= {NBITS{1'b0}};
            idx_r   <= IDX_BITS'(0);
        end else if (load) begin
            shreg_r <= word;
            idx_r   <= IDX_BITS'(0);
        end else if (next) begin
            if (MSB_FIRST != 0) begin
                shreg_r <= shreg_r << DATA_BITS;
            end else begin
                shreg_r <= shreg_r >> DATA_BITS;
            end
            idx_r <= idx_r + IDX_BITS'(1);
        end else begin
            shreg_r <= shreg_r;
            idx_r   <= idx_r;
        end
    end

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign tx_byte = shreg_r[NBITS-1 -: DATA_BITS];
        end else begin : g_lsb_first
            assign tx_byte = shreg_r[DATA_BITS-1:0];
        end
    endgenerate

    assign last = (idx_r == IDX_BITS'(B - 1));

endmodule

// File: rtl/debug_dump_unit.sv
// -----------------------------------------------------------------------------
// debug_dump_unit
// Run-control and state-dump sequencer between the byte UART and the MIPS core.
// Gates the core clock enable for RUN/STEP, counts enabled cycles, and on halt
// or step completion streams counter, PC, N_REGS registers and N_MEM_WORDS
// memory words (from address 0) as bytes over the UART TX handshake.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-low reset
//   i_cmd_valid, i_cmd    command strobe / code (nop, run, step, dump-only)
//   i_halt                core halted (level)
//   i_mips_pc             current PC
//   i_data_reg_file       register word at o_select_reg_dir (1-cycle latency)
//   i_data_mem            memory word at o_select_mem_dir (1-cycle latency)
//   i_tx_done             UART byte-sent pulse
//   o_tx_start, o_tx_data TX request pulse and byte (held until i_tx_done)
//   o_select_reg_dir      register read address
//   o_select_mem_dir      memory word address
//   o_control_clk_wiz     core clock enable
//   o_cycle_count         enabled-cycle count
//   o_busy, o_debug_state activity flag and raw FSM state
//
// Optional: define DEBUG_DUMP_CHECKSUM_EN to append one byte equal to the XOR
// of every dump byte, sent with the same handshake before DONE.
// -----------------------------------------------------------------------------
module debug_dump_unit
    import debug_pkg::*;
#(
    parameter int NBITS       = 32,
    parameter int DATA_BITS   = 8,
    parameter int N_REGS      = 32,
    parameter int N_MEM_WORDS = 16,
    parameter int CNT_BITS    = 32,
    parameter int MSB_FIRST   = 0
)(
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_cmd_valid,
    input  logic [1:0]                 i_cmd,
    input  logic                       i_halt,
    input  logic [NBITS-1:0]           i_mips_pc,
    input  logic [NBITS-1:0]           i_data_reg_file,
    input  logic [NBITS-1:0]           i_data_mem,
    input  logic                       i_tx_done,
    output logic                       o_tx_start,
    output logic [DATA_BITS-1:0]       o_tx_data,
    output logic [$clog2(N_REGS)-1:0]  o_select_reg_dir,
    output logic [NBITS-1:0]           o_select_mem_dir,
    output logic                       o_control_clk_wiz,
    output logic [CNT_BITS-1:0]        o_cycle_count,
    output logic                       o_busy,
    output logic [3:0]                 o_debug_state
);

    localparam int REG_AW    = $clog2(N_REGS);
    localparam int NWORDS    = total_words(N_REGS, N_MEM_WORDS);
    localparam int WIDX_BITS = $clog2(NWORDS + 1);
    localparam int FIRST_REG = 2;
    localparam int FIRST_MEM = 2 + N_REGS;

    state_e                 state_r;
    logic [CNT_BITS-1:0]    cnt_r;
    logic [WIDX_BITS-1:0]   word_r;
    logic [REG_AW-1:0]      reg_dir_r;
    logic [NBITS-1:0]       mem_dir_r;
    logic [NBITS-1:0]       pc_r;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [DATA_BITS-1:0]   chk_r;
    logic                   chk_phase_r;
`endif

    logic [NBITS-1:0]       word_s;
    int                     nxt_idx_s;
    logic [REG_AW-1:0]      nxt_reg_s;
    logic [NBITS-1:0]       nxt_mem_s;
    logic                   last_word_s;
    logic                   ser_load_s;
    logic                   ser_next_s;
    logic                   ser_last_s;
    logic [DATA_BITS-1:0]   ser_byte_s;

    assign last_word_s = (word_r == WIDX_BITS'(NWORDS - 1));
    assign ser_load_s  = (state_r == ST_LATCH);
    // The final byte of a word is never shifted out; the next load replaces it.
    assign ser_next_s  = (state_r == ST_WAIT) && i_tx_done && !ser_last_s;

    // Select the word to latch; memories were addressed one cycle earlier in LOAD.
    always_comb begin
        word_s = {NBITS{1'b0}};
        if (word_r == WIDX_BITS'(0)) begin
            word_s = NBITS'(cnt_r);
        end else if (word_r == WIDX_BITS'(1)) begin
            word_s = pc_r;
        end else if (int'(word_r) < FIRST_MEM) begin
            word_s = i_data_reg_file;
        end else begin
            word_s = i_data_mem;
        end
    end

    // Addresses for the following word, applied on the edge into LOAD.
    always_comb begin
        nxt_idx_s = int'(word_r) + 32'sd1;
        nxt_reg_s = REG_AW'(0);
        nxt_mem_s = NBITS'(0);
        if (nxt_idx_s >= FIRST_REG && nxt_idx_s < FIRST_MEM) begin
            nxt_reg_s = REG_AW'(nxt_idx_s - FIRST_REG);
        end else if (nxt_idx_s >= FIRST_MEM) begin
            nxt_mem_s = NBITS'(nxt_idx_s - FIRST_MEM);
        end else begin
            nxt_reg_s = REG_AW'(0);
            nxt_mem_s = NBITS'(0);
        end
    end

    debug_word_serializer #(
        .NBITS     (NBITS),
        .DATA_BITS (DATA_BITS),
        .MSB_FIRST (MSB_FIRST)
    ) u_ser (
        .clk     (i_clk),
        .rst_n   (i_reset),
        .load    (ser_load_s),
        .next    (ser_next_s),
        .word    (word_s),
        .tx_byte (ser_byte_s),
        .last    (ser_last_s)
    );

    // Run-control and dump sequencer.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_BITS{1'b0}};
            word_r      <= WIDX_BITS'(0);
            reg_dir_r   <= REG_AW'(0);
            mem_dir_r   <= NBITS'(0);
            pc_r        <= NBITS'(0);
`ifdef DEBUG_DUMP_CHECKSUM_EN
            chk_r       <= DATA_BITS'(0);
            chk_phase_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    word_r    <= WIDX_BITS'(0);
                    reg_dir_r <= REG_AW'(0);
                    mem_dir_r <= NBITS'(0);
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    chk_r       <= DATA_BITS'(0);
                    chk_phase_r <= 1'b0;
`endif
                    if (i_cmd_valid) begin
                        case (i_cmd)
                            CMD_RUN:  state_r <= i_halt ? ST_LOAD : ST_RUN;
                            CMD_STEP: state_r <= i_halt ? ST_LOAD : ST_STEP;
                            CMD_DUMP: state_r <= ST_LOAD;
                            default:  state_r <= ST_IDLE;
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // The enable is already off combinationally while halted.
                    if (i_halt) begin
                        state_r <= ST_LOAD;
                    end else begin
                        cnt_r <= cnt_r + CNT_BITS'(1);
                    end
                end
                ST_STEP: begin
                    cnt_r   <= cnt_r + CNT_BITS'(1);
                    state_r <= ST_LOAD;
                end
                ST_LOAD: begin
                    // Freeze the PC once, at the start of the dump.
                    if (word_r == WIDX_BITS'(0)) begin
                        pc_r <= i_mips_pc;
                    end else begin
                        pc_r <= pc_r;
                    end
                    state_r <= ST_LATCH;
                end
                ST_LATCH: begin
                    state_r <= ST_SEND;
                end
                ST_SEND: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        if (chk_phase_r) begin
                            state_r <= ST_DONE;
                        end else begin
                            chk_r <= chk_r ^ ser_byte_s;
`endif
                            if (!ser_last_s) begin
                                state_r <= ST_SEND;
                            end else if (!last_word_s) begin
                                word_r    <= word_r + WIDX_BITS'(1);
                                reg_dir_r <= nxt_reg_s;
                                mem_dir_r <= nxt_mem_s;
                                state_r   <= ST_LOAD;
                            end else begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                                chk_phase_r <= 1'b1;
                                state_r     <= ST_SEND;
`else
                                state_r <= ST_DONE;
`endif
                            end
`ifdef DEBUG_DUMP_CHECKSUM_EN
                        end
`endif
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    word_r    <= WIDX_BITS'(0);
                    reg_dir_r <= REG_AW'(0);
                    mem_dir_r <= NBITS'(0);
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_control_clk_wiz = ((state_r == ST_RUN) && !i_halt) || (state_r == ST_STEP);
    assign o_tx_start        = (state_r == ST_SEND);
`ifdef DEBUG_DUMP_CHECKSUM_EN
    assign o_tx_data         = chk_phase_r ? chk_r : ser_byte_s;
`else
    assign o_tx_data         = ser_byte_s;
`endif
    assign o_select_reg_dir  = reg_dir_r;
    assign o_select_mem_dir  = mem_dir_r;
    assign o_cycle_count     = cnt_r;
    assign o_busy            = (state_r != ST_IDLE);
    assign o_debug_state     = state_r;

endmodule
